// File: rtl/dual_core_mem_arbiter_if.sv
// Bundle of both cores' memory-side signals plus the shared physical memory port.
// The arbiter takes the slave view; cores and the memory together form the master view.
interface dual_core_mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          c0_memread;
  logic          c0_memwrite;
  logic [AW-1:0] c0_adr;
  logic [DW-1:0] c0_writedata;
  logic [DW-1:0] c0_memdata;
  logic          c0_done;
  logic          c0_stall;

  logic          c1_memread;
  logic          c1_memwrite;
  logic [AW-1:0] c1_adr;
  logic [DW-1:0] c1_writedata;
  logic [DW-1:0] c1_memdata;
  logic          c1_done;
  logic          c1_stall;

  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_writedata;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  c0_memread, c0_memwrite, c0_adr, c0_writedata,
    output c0_memdata, c0_done, c0_stall,
    input  c1_memread, c1_memwrite, c1_adr, c1_writedata,
    output c1_memdata, c1_done, c1_stall,
    output mem_adr, mem_writedata, mem_read, mem_write,
    input  mem_rdata
  );

  modport master (
    output c0_memread, c0_memwrite, c0_adr, c0_writedata,
    input  c0_memdata, c0_done, c0_stall,
    output c1_memread, c1_memwrite, c1_adr, c1_writedata,
    input  c1_memdata, c1_done, c1_stall,
    input  mem_adr, mem_writedata, mem_read, mem_write,
    output mem_rdata
  );
endinterface

// File: rtl/dual_core_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency byte memory between two multicycle cores.
// Each access takes IDLE -> BUSY (LAT cycles of strobe) -> RESP (done pulse) -> IDLE.
module dual_core_mem_arbiter #(
  parameter int AW  = 8,
  parameter int DW  = 8,
  parameter int LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  dual_core_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] CNT_LAST = 4'(LAT - 1);

  state_t        state;
  logic [3:0]    cnt;
  logic          owner;
  logic          last;
  logic          op_write;
  logic [AW-1:0] mem_adr_q;
  logic [DW-1:0] mem_writedata_q;
  logic          mem_read_q;
  logic          mem_write_q;
  logic [DW-1:0] c0_memdata_q;
  logic [DW-1:0] c1_memdata_q;
  logic          c0_done_q;
  logic          c1_done_q;

  logic          req0;
  logic          req1;
  logic          grant_core;
  logic          sel_write;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_writedata;

  assign req0 = bus.c0_memread | bus.c0_memwrite;
  assign req1 = bus.c1_memread | bus.c1_memwrite;

  // On a tie the core that was not served last wins; write dominates a read+write request.
  always_comb begin
    grant_core    = (req0 && req1) ? ~last : req1;
    sel_write     = grant_core ? bus.c1_memwrite  : bus.c0_memwrite;
    sel_adr       = grant_core ? bus.c1_adr       : bus.c0_adr;
    sel_writedata = grant_core ? bus.c1_writedata : bus.c0_writedata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cnt             <= '0;
      owner           <= 1'b0;
      last            <= 1'b1;
      op_write        <= 1'b0;
      mem_adr_q       <= '0;
      mem_writedata_q <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      c0_memdata_q    <= '0;
      c1_memdata_q    <= '0;
      c0_done_q       <= 1'b0;
      c1_done_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner           <= grant_core;
            op_write        <= sel_write;
            mem_adr_q       <= sel_adr;
            mem_writedata_q <= sel_writedata;
            mem_read_q      <= ~sel_write;
            mem_write_q     <= sel_write;
            cnt             <= '0;
            state           <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == CNT_LAST) begin
            if (!op_write) begin
              if (owner) c1_memdata_q <= bus.mem_rdata;
              else       c0_memdata_q <= bus.mem_rdata;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            c0_done_q   <= ~owner;
            c1_done_q   <= owner;
            state       <= RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          c0_done_q <= 1'b0;
          c1_done_q <= 1'b0;
          last      <= owner;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_adr       = mem_adr_q;
  assign bus.mem_writedata = mem_writedata_q;
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.c0_memdata    = c0_memdata_q;
  assign bus.c1_memdata    = c1_memdata_q;
  assign bus.c0_done       = c0_done_q;
  assign bus.c1_done       = c1_done_q;
  assign bus.c0_stall      = req0 & ~c0_done_q;
  assign bus.c1_stall      = req1 & ~c1_done_q;

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// Directed bench for dual_core_mem_arbiter: one instance at LAT=1, one at LAT=3,
// each with a small ROM-style memory model that only presents valid data on the last strobe cycle.
module tb_dual_core_mem_arbiter;

  logic clk;
  logic reset;

  int vectors;
  int miscompares;
  int overlap;

  dual_core_mem_arbiter_if #(.AW(8), .DW(8)) bus1 ();
  dual_core_mem_arbiter_if #(.AW(8), .DW(8)) bus3 ();

  dual_core_mem_arbiter #(.AW(8), .DW(8), .LAT(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  dual_core_mem_arbiter #(.AW(8), .DW(8), .LAT(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] romVal(input logic [7:0] a);
    case (a)
      8'h10:   romVal = 8'h55;
      8'h08:   romVal = 8'h77;
      8'hFF:   romVal = 8'hA5;
      default: romVal = a ^ 8'h3C;
    endcase
  endfunction

  // Memory models: read data is garbage (0xEE) except on the LAT-th strobe cycle.
  int         rd1;
  int         rd3;
  logic [7:0] lastWrAdr1;
  logic [7:0] lastWrData1;

  initial begin
    rd1 = 0;
    rd3 = 0;
    lastWrAdr1 = 8'h00;
    lastWrData1 = 8'h00;
  end

  always @(posedge clk) begin
    rd1 <= bus1.mem_read ? rd1 + 1 : 0;
    rd3 <= bus3.mem_read ? rd3 + 1 : 0;
    if (bus1.mem_write) begin
      lastWrAdr1  <= bus1.mem_adr;
      lastWrData1 <= bus1.mem_writedata;
    end
  end

  assign bus1.mem_rdata = (bus1.mem_read && rd1 == 0) ? romVal(bus1.mem_adr) : 8'hEE;
  assign bus3.mem_rdata = (bus3.mem_read && rd3 == 2) ? romVal(bus3.mem_adr) : 8'hEE;

  initial overlap = 0;
  always @(negedge clk) begin
    if (bus1.c0_done && bus1.c1_done) overlap <= overlap + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int unit, input int core, input logic rd, input logic wr,
                               input logic [7:0] adr, input logic [7:0] wd);
    if (unit == 1) begin
      if (core == 0) begin
        bus1.c0_memread = rd; bus1.c0_memwrite = wr; bus1.c0_adr = adr; bus1.c0_writedata = wd;
      end else begin
        bus1.c1_memread = rd; bus1.c1_memwrite = wr; bus1.c1_adr = adr; bus1.c1_writedata = wd;
      end
    end else begin
      if (core == 0) begin
        bus3.c0_memread = rd; bus3.c0_memwrite = wr; bus3.c0_adr = adr; bus3.c0_writedata = wd;
      end else begin
        bus3.c1_memread = rd; bus3.c1_memwrite = wr; bus3.c1_adr = adr; bus3.c1_writedata = wd;
      end
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int order[$];
    int n0;
    int n1;
    logic re0;
    logic re1;

    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    applyStimulus(1, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1, 1, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(3, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(3, 1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    checkOutput("rst_mem_read",   32'(bus1.mem_read), 32'h0);
    checkOutput("rst_mem_adr",    32'(bus1.mem_adr), 32'h0);
    checkOutput("rst_c0_memdata", 32'(bus1.c0_memdata), 32'h0);
    checkOutput("rst_c0_done",    32'(bus1.c0_done), 32'h0);
    reset = 1'b1;
    tick();

    $display("[TB] single read, LAT=1");
    applyStimulus(1, 0, 1'b1, 1'b0, 8'h10, 8'h00);
    checkOutput("t1_stall_req", 32'(bus1.c0_stall), 32'h1);
    tick();
    checkOutput("t1_mem_read", 32'(bus1.mem_read), 32'h1);
    checkOutput("t1_mem_adr",  32'(bus1.mem_adr), 32'h10);
    checkOutput("t1_no_done",  32'(bus1.c0_done), 32'h0);
    tick();
    checkOutput("t1_strobe_off", 32'(bus1.mem_read), 32'h0);
    checkOutput("t1_done",       32'(bus1.c0_done), 32'h1);
    checkOutput("t1_stall_done", 32'(bus1.c0_stall), 32'h0);
    checkOutput("t1_c0_memdata", 32'(bus1.c0_memdata), 32'h55);
    checkOutput("t1_c1_memdata", 32'(bus1.c1_memdata), 32'h0);
    applyStimulus(1, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    checkOutput("t1_idle_again", 32'(bus1.mem_read), 32'h0);

    $display("[TB] simultaneous requests after reset");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    applyStimulus(1, 0, 1'b0, 1'b1, 8'h04, 8'h24);
    applyStimulus(1, 1, 1'b1, 1'b0, 8'h08, 8'h00);
    tick();
    checkOutput("t2_mem_write", 32'(bus1.mem_write), 32'h1);
    checkOutput("t2_mem_adr",   32'(bus1.mem_adr), 32'h04);
    checkOutput("t2_mem_wd",    32'(bus1.mem_writedata), 32'h24);
    checkOutput("t2_c1_stall1", 32'(bus1.c1_stall), 32'h1);
    tick();
    checkOutput("t2_c0_done",   32'(bus1.c0_done), 32'h1);
    checkOutput("t2_c1_stall2", 32'(bus1.c1_stall), 32'h1);
    checkOutput("t2_wr_adr",    32'(lastWrAdr1), 32'h04);
    checkOutput("t2_wr_data",   32'(lastWrData1), 32'h24);
    applyStimulus(1, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checkOutput("t2_c1_stall3", 32'(bus1.c1_stall), 32'h1);
    tick();
    checkOutput("t2_c1_read",   32'(bus1.mem_read), 32'h1);
    checkOutput("t2_c1_adr",    32'(bus1.mem_adr), 32'h08);
    tick();
    checkOutput("t2_c1_done",    32'(bus1.c1_done), 32'h1);
    checkOutput("t2_c1_memdata", 32'(bus1.c1_memdata), 32'h77);
    checkOutput("t2_c0_memdata", 32'(bus1.c0_memdata), 32'h0);
    applyStimulus(1, 1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();

    $display("[TB] fairness under contention");
    n0 = 0;
    n1 = 0;
    re0 = 1'b0;
    re1 = 1'b0;
    applyStimulus(1, 0, 1'b1, 1'b0, 8'h10, 8'h00);
    applyStimulus(1, 1, 1'b1, 1'b0, 8'h08, 8'h00);
    for (int cyc = 0; cyc < 80 && order.size() < 6; cyc++) begin
      tick();
      if (re0) begin applyStimulus(1, 0, 1'b1, 1'b0, 8'h10, 8'h00); re0 = 1'b0; end
      if (re1) begin applyStimulus(1, 1, 1'b1, 1'b0, 8'h08, 8'h00); re1 = 1'b0; end
      if (bus1.c0_done) begin
        order.push_back(0);
        n0++;
        applyStimulus(1, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        re0 = (n0 < 3);
      end
      if (bus1.c1_done) begin
        order.push_back(1);
        n1++;
        applyStimulus(1, 1, 1'b0, 1'b0, 8'h00, 8'h00);
        re1 = (n1 < 3);
      end
    end
    applyStimulus(1, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1, 1, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("t3_grant_count", 32'(order.size()), 32'd6);
    for (int i = 0; i < order.size(); i++) begin
      checkOutput($sformatf("t3_grant%0d", i), 32'(order[i]), 32'(i % 2));
    end
    tick();
    tick();

    $display("[TB] single read, LAT=3");
    applyStimulus(3, 1, 1'b1, 1'b0, 8'hFF, 8'h00);
    tick();
    checkOutput("t4_strobe1", 32'(bus3.mem_read), 32'h1);
    checkOutput("t4_adr",     32'(bus3.mem_adr), 32'hFF);
    tick();
    checkOutput("t4_strobe2", 32'(bus3.mem_read), 32'h1);
    tick();
    checkOutput("t4_strobe3", 32'(bus3.mem_read), 32'h1);
    checkOutput("t4_early_done", 32'(bus3.c1_done), 32'h0);
    checkOutput("t4_stall",   32'(bus3.c1_stall), 32'h1);
    tick();
    checkOutput("t4_strobe_off", 32'(bus3.mem_read), 32'h0);
    checkOutput("t4_done",       32'(bus3.c1_done), 32'h1);
    checkOutput("t4_c1_memdata", 32'(bus3.c1_memdata), 32'hA5);
    checkOutput("t4_c0_memdata", 32'(bus3.c0_memdata), 32'h0);
    applyStimulus(3, 1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();

    $display("[TB] reset during an access");
    applyStimulus(1, 0, 1'b1, 1'b0, 8'h10, 8'h00);
    applyStimulus(3, 0, 1'b1, 1'b0, 8'h20, 8'h00);
    tick();
    checkOutput("t5_busy1", 32'(bus1.mem_read), 32'h1);
    checkOutput("t5_busy3", 32'(bus3.mem_read), 32'h1);
    reset = 1'b0;
    #1;
    checkOutput("t5_strobe1_drop", 32'(bus1.mem_read), 32'h0);
    checkOutput("t5_strobe3_drop", 32'(bus3.mem_read), 32'h0);
    checkOutput("t5_memdata1_clr", 32'(bus1.c0_memdata), 32'h0);
    checkOutput("t5_memdata3_clr", 32'(bus3.c1_memdata), 32'h0);
    applyStimulus(3, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1, 1, 1'b1, 1'b0, 8'h08, 8'h00);
    tick();
    checkOutput("t5_no_done", 32'(bus1.c0_done), 32'h0);
    reset = 1'b1;
    tick();
    checkOutput("t5_tie_adr",  32'(bus1.mem_adr), 32'h10);
    checkOutput("t5_tie_read", 32'(bus1.mem_read), 32'h1);
    tick();
    checkOutput("t5_c0_done",    32'(bus1.c0_done), 32'h1);
    checkOutput("t5_c1_notdone", 32'(bus1.c1_done), 32'h0);
    checkOutput("t5_c0_memdata", 32'(bus1.c0_memdata), 32'h55);
    applyStimulus(1, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    tick();
    checkOutput("t5_c1_done", 32'(bus1.c1_done), 32'h1);
    applyStimulus(1, 1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();

    $display("[TB] inputs changed after grant");
    applyStimulus(1, 0, 1'b1, 1'b1, 8'h30, 8'h99);
    tick();
    checkOutput("t6_write",    32'(bus1.mem_write), 32'h1);
    checkOutput("t6_no_read",  32'(bus1.mem_read), 32'h0);
    applyStimulus(1, 0, 1'b1, 1'b0, 8'h31, 8'h11);
    checkOutput("t6_adr_held", 32'(bus1.mem_adr), 32'h30);
    checkOutput("t6_wd_held",  32'(bus1.mem_writedata), 32'h99);
    tick();
    checkOutput("t6_done",     32'(bus1.c0_done), 32'h1);
    checkOutput("t6_wr_adr",   32'(lastWrAdr1), 32'h30);
    checkOutput("t6_wr_data",  32'(lastWrData1), 32'h99);
    checkOutput("t6_memdata",  32'(bus1.c0_memdata), 32'h55);
    applyStimulus(1, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();

    checkOutput("done_overlap", 32'(overlap), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
